alu_seq8: RTL and testbench

Two-pass 8-bit ALU sequencer sitting directly upstream of the 4-bit `alu_core` nibble slice. It latches an 8-bit operation and drives the combinational core twice, low nibble then high nibble. It chains carry between the passes and assembles the 8-bit result plus Z80 flags (S, Z, H, P/V, N, C). Results go to the flag and register write-back logic through a one-cycle valid pulse.

---
 rtl/alu_seq8.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq8.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq8.sv
// Two-pass 8-bit ALU sequencer: drives a 4-bit combinational core low nibble then high
// nibble, chains carry between passes and assembles the 8-bit result with Z80 flags.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | ready; waiting for start, core inputs held at 0
// ST_LO   | core computes low nibble from latched operands
// ST_HI   | core computes high nibble; result/flags captured
// ST_DONE | valid pulse; core inputs held at 0
module alu_seq8 (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cf_in,
    output logic       ready,
    output logic       valid,
    output logic [7:0] result,
    output logic [7:0] flags,
    output logic [3:0] core_op1,
    output logic [3:0] core_op2,
    output logic       core_cy_in,
    output logic       core_R,
    output logic       core_S,
    output logic       core_V,
    input  logic [3:0] core_result,
    input  logic       core_cy_out,
    input  logic       core_vf_out
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_CP  = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_cf;
    logic [3:0] r_res_lo;
    logic       r_hc;
    logic [7:0] r_result;
    logic [7:0] r_flags;

    logic       w_is_sub;
    logic       w_is_logic;
    logic       w_cy_lo;
    logic       w_r;
    logic       w_s;
    logic       w_v;
    logic [7:0] w_res_full;
    logic       w_h;
    logic       w_c;
    logic       w_pv;
    logic [7:0] w_flags_nxt;

    assign w_is_sub   = (r_op == OP_SUB) || (r_op == OP_SBC) || (r_op == OP_CP);
    assign w_is_logic = (r_op == OP_AND) || (r_op == OP_XOR) || (r_op == OP_OR);

    always_comb begin
        w_cy_lo = 1'b0;
        w_r     = 1'b0;
        w_s     = 1'b0;
        w_v     = 1'b0;
        case (r_op)
            OP_ADD:  w_cy_lo = 1'b0;
            OP_ADC:  w_cy_lo = r_cf;
            OP_SUB:  w_cy_lo = 1'b1;
            OP_SBC:  w_cy_lo = ~r_cf;
            OP_CP:   w_cy_lo = 1'b1;
            OP_AND: begin
                w_s     = 1'b1;
                w_cy_lo = 1'b1;
            end
            OP_XOR:  w_r = 1'b1;
            OP_OR: begin
                w_r = 1'b1;
                w_s = 1'b1;
                w_v = 1'b1;
            end
            default: w_cy_lo = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        valid       = 1'b0;
        core_op1    = 4'h0;
        core_op2    = 4'h0;
        core_cy_in  = 1'b0;
        core_R      = 1'b0;
        core_S      = 1'b0;
        core_V      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) w_state_nxt = ST_LO;
            end
            ST_LO: begin
                core_op1    = r_a[3:0];
                core_op2    = w_is_sub ? ~r_b[3:0] : r_b[3:0];
                core_cy_in  = w_cy_lo;
                core_R      = w_r;
                core_S      = w_s;
                core_V      = w_v;
                w_state_nxt = ST_HI;
            end
            ST_HI: begin
                core_op1    = r_a[7:4];
                core_op2    = w_is_sub ? ~r_b[7:4] : r_b[7:4];
                // logic ops keep their fixed carry-in; arithmetic chains the half carry
                core_cy_in  = w_is_logic ? w_cy_lo : r_hc;
                core_R      = w_r;
                core_S      = w_s;
                core_V      = w_v;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                valid       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Flags are formed from the latched low half, half carry and the live high pass,
    // then registered so they hold until the next DONE.
    assign w_res_full = {core_result, r_res_lo};

    always_comb begin
        w_h  = 1'b0;
        w_c  = 1'b0;
        w_pv = ~^w_res_full;
        if (!w_is_logic) begin
            w_h  = w_is_sub ? ~r_hc : r_hc;
            w_c  = w_is_sub ? ~core_cy_out : core_cy_out;
            w_pv = core_vf_out;
        end else if (r_op == OP_AND) begin
            w_h = 1'b1;
        end
    end

    assign w_flags_nxt = {w_res_full[7], (w_res_full == 8'h00), 1'b0, w_h,
                          1'b0, w_pv, w_is_sub, w_c};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_op     <= 3'b000;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_cf     <= 1'b0;
            r_res_lo <= 4'h0;
            r_hc     <= 1'b0;
            r_result <= 8'h00;
            r_flags  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                        r_cf <= cf_in;
                    end
                end
                ST_LO: begin
                    r_res_lo <= core_result;
                    r_hc     <= core_cy_out;
                end
                ST_HI: begin
                    r_result <= w_res_full;
                    r_flags  <= w_flags_nxt;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_alu_seq8.sv
// Directed bench for alu_seq8 with a behavioural nibble core model; vectors carry
// hand-computed result/flag values, plus sequences for core drive, ignored start and reset.
module tb_alu_seq8;

    logic       clk;
    logic       nreset;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cf_in;
    logic       ready;
    logic       valid;
    logic [7:0] result;
    logic [7:0] flags;
    logic [3:0] core_op1;
    logic [3:0] core_op2;
    logic       core_cy_in;
    logic       core_R;
    logic       core_S;
    logic       core_V;
    logic [3:0] core_result;
    logic       core_cy_out;
    logic       core_vf_out;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq8 dut (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .cf_in      (cf_in),
        .ready      (ready),
        .valid      (valid),
        .result     (result),
        .flags      (flags),
        .core_op1   (core_op1),
        .core_op2   (core_op2),
        .core_cy_in (core_cy_in),
        .core_R     (core_R),
        .core_S     (core_S),
        .core_V     (core_V),
        .core_result(core_result),
        .core_cy_out(core_cy_out),
        .core_vf_out(core_vf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nibble core model: R/S select add, AND, XOR, OR.
    logic [4:0] m_sum;
    always_comb begin
        m_sum       = {1'b0, core_op1} + {1'b0, core_op2} + {4'b0, core_cy_in};
        core_result = m_sum[3:0];
        core_cy_out = 1'b0;
        core_vf_out = 1'b0;
        case ({core_R, core_S})
            2'b00: begin
                core_cy_out = m_sum[4];
                core_vf_out = (core_op1[3] == core_op2[3]) && (m_sum[3] != core_op1[3]);
            end
            2'b01:   core_result = core_op1 & core_op2;
            2'b10:   core_result = core_op1 ^ core_op2;
            default: core_result = core_op1 | core_op2;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic c, output logic [7:0] r, output logic [7:0] f,
                          output int lat);
        @(negedge clk);
        op = o; a = x; b = y; cf_in = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; a = ~x; b = ~y; cf_in = ~c;
        lat = 0; r = 8'h00; f = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (valid) begin
                lat = k; r = result; f = flags;
                break;
            end
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cf;
        logic [7:0] res;
        logic [7:0] flg;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [7:0] r;
        logic [7:0] f;
        int         lat;
        int         seen;

        vecs[0]  = '{3'b000, 8'h3A, 8'hC6, 1'b0, 8'h00, 8'h51};
        vecs[1]  = '{3'b001, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h94};
        vecs[2]  = '{3'b001, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h51};
        vecs[3]  = '{3'b010, 8'h10, 8'h01, 1'b0, 8'h0F, 8'h12};
        vecs[4]  = '{3'b010, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h93};
        vecs[5]  = '{3'b011, 8'h10, 8'h01, 1'b1, 8'h0E, 8'h12};
        vecs[6]  = '{3'b111, 8'h05, 8'h05, 1'b0, 8'h00, 8'h42};
        vecs[7]  = '{3'b100, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h14};
        vecs[8]  = '{3'b110, 8'h00, 8'h00, 1'b1, 8'h00, 8'h44};
        vecs[9]  = '{3'b101, 8'hFF, 8'h01, 1'b0, 8'hFE, 8'h80};
        vecs[10] = '{3'b000, 8'h0F, 8'h01, 1'b0, 8'h10, 8'h10};
        vecs[11] = '{3'b010, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h16};
        vecs[12] = '{3'b110, 8'h0A, 8'h50, 1'b0, 8'h5A, 8'h04};

        nreset = 1'b0; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00; cf_in = 1'b0;
        #2;
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_result", result, 8'h00);
        check("rst_flags", flags, 8'h00);
        check("rst_core", {core_op1, core_op2, core_cy_in, core_R, core_S, core_V}, 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cf, r, f, lat);
            check($sformatf("v%0d_latency", i), lat, 3);
            check($sformatf("v%0d_result", i), r, vecs[i].res);
            check($sformatf("v%0d_flags", i), f, vecs[i].flg);
            @(negedge clk);
            check($sformatf("v%0d_valid_drop", i), valid, 0);
            check($sformatf("v%0d_ready_back", i), ready, 1);
            check($sformatf("v%0d_result_hold", i), result, vecs[i].res);
        end

        // Core drive for ADD 3A+C6, with start re-pulsed during LO/HI
        @(negedge clk);
        op = 3'b000; a = 8'h3A; b = 8'hC6; cf_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("lo_op1", core_op1, 4'hA);
        check("lo_op2", core_op2, 4'h6);
        check("lo_cy", core_cy_in, 0);
        check("lo_ctl", {core_R, core_S, core_V}, 0);
        check("lo_ready", ready, 0);
        start = 1'b1; op = 3'b110; a = 8'hFF; b = 8'h55;
        @(negedge clk);
        check("hi_op1", core_op1, 4'h3);
        check("hi_op2", core_op2, 4'hC);
        check("hi_cy", core_cy_in, 1);
        check("hi_valid", valid, 0);
        @(negedge clk);
        start = 1'b0;
        check("done_valid", valid, 1);
        check("done_core", {core_op1, core_op2, core_cy_in}, 0);
        check("ign_result", result, 8'h00);
        check("ign_flags", flags, 8'h51);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("ign_no_extra_valid", seen, 0);
        check("ign_ready", ready, 1);

        // Reset during HI after a nonzero result
        run_op(3'b101, 8'hFF, 8'h01, 1'b0, r, f, lat);
        check("pre_rst_result", r, 8'hFE);
        @(negedge clk);
        op = 3'b010; a = 8'h10; b = 8'h01; cf_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("in_hi_op1", core_op1, 4'h1);
        nreset = 1'b0;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_result", result, 8'h00);
        check("mid_rst_flags", flags, 8'h00);
        check("mid_rst_core", {core_op1, core_op2, core_cy_in, core_R, core_S, core_V}, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("mid_rst_no_valid", seen, 0);
        nreset = 1'b1;
        run_op(3'b000, 8'h7F, 8'h01, 1'b0, r, f, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_result", r, 8'h80);
        check("post_rst_flags", f, 8'h94);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
